// File: rtl/spectrum_mag_buffer.sv
// FFT output sink: approximate |X[k]| per bin and keep the positive-frequency half of each
// frame in a ping-pong RAM. Only frames with correct tlast framing are published.
module spectrum_mag_buffer #(
  parameter  int FFT_LEN         = 1024,
  parameter  int FFT_RE_IM_WIDTH = 16,
  localparam int AW              = $clog2(FFT_LEN/2),
  localparam int W               = FFT_RE_IM_WIDTH
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             m_axis_tvalid,
  output logic             m_axis_tready,
  input  logic [2*W-1:0]   m_axis_tdata,
  input  logic             m_axis_tlast,
  input  logic [AW-1:0]    rd_addr,
  output logic [W-1:0]     rd_data,
  output logic             bank_sel,
  output logic             frame_done,
  output logic             frame_err
);

  localparam int CW   = $clog2(FFT_LEN);
  localparam int HALF = FFT_LEN/2;

  typedef enum logic [1:0] {
    FE_NONE,
    FE_GOOD,
    FE_BAD
  } frame_end_e;

  function automatic logic [W-1:0] abs_w(input logic [W-1:0] x);
    return x[W-1] ? (~x + 1'b1) : x;
  endfunction

  logic             accept;
  logic             last_bin;
  logic [CW-1:0]    bin_cnt_q, bin_cnt_d;
  frame_end_e       fend_d;

  logic             s1_vld_q;
  logic [W-1:0]     s1_a_q, s1_b_q;
  logic [CW-1:0]    s1_bin_q;
  frame_end_e       s1_fend_q;

  logic [W-1:0]     mx, mn, mag;
  logic             wr_en;
  logic             bank_sel_q, bank_sel_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [W-1:0]     rd_data_q;

  logic [W-1:0]     mem_q [2*HALF];

  assign m_axis_tready = rst_n;
  assign accept        = m_axis_tvalid && m_axis_tready;
  assign last_bin      = (bin_cnt_q == CW'(FFT_LEN-1));

  // Frame check happens on the beat that either carries tlast or wraps the counter.
  always_comb begin
    bin_cnt_d = bin_cnt_q;
    fend_d    = FE_NONE;
    if (accept) begin
      if (m_axis_tlast || last_bin) begin
        bin_cnt_d = '0;
        fend_d    = (m_axis_tlast && last_bin) ? FE_GOOD : FE_BAD;
      end else begin
        bin_cnt_d = bin_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      bin_cnt_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_bin_q  <= '0;
      s1_fend_q <= FE_NONE;
    end else begin
      bin_cnt_q <= bin_cnt_d;
      s1_vld_q  <= accept;
      s1_a_q    <= abs_w(m_axis_tdata[2*W-1:W]);
      s1_b_q    <= abs_w(m_axis_tdata[W-1:0]);
      s1_bin_q  <= bin_cnt_q;
      s1_fend_q <= fend_d;
    end
  end

  // Peak of max + 3/8*min is 11/8 * 2^(W-1), which still fits in W bits.
  always_comb begin
    mx         = (s1_a_q >= s1_b_q) ? s1_a_q : s1_b_q;
    mn         = (s1_a_q >= s1_b_q) ? s1_b_q : s1_a_q;
    mag        = mx + (mn >> 2) + (mn >> 3);
    wr_en      = s1_vld_q && (s1_bin_q < CW'(HALF));
    done_d     = s1_vld_q && (s1_fend_q == FE_GOOD);
    err_d      = s1_vld_q && (s1_fend_q == FE_BAD);
    bank_sel_d = bank_sel_q ^ done_d;
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      bank_sel_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      bank_sel_q <= bank_sel_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // RAM survives reset; the write bank and display bank are always distinct.
  always_ff @(posedge clk_50m) begin
    if (wr_en) begin
      mem_q[{bank_sel_q, s1_bin_q[AW-1:0]}] <= mag;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[{~bank_sel_q, rd_addr}];
    end
  end

  assign rd_data    = rd_data_q;
  assign bank_sel   = bank_sel_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_spectrum_mag_buffer.sv
// Directed bench for spectrum_mag_buffer: magnitude values, publish timing, framing errors,
// bursty input and mid-frame reset against a per-bank expected-content model.
module tb_spectrum_mag_buffer;

  logic        clk;
  logic        rst_n;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tlast;
  logic [8:0]  rd_addr;
  logic [15:0] rd_data;
  logic        bank_sel;
  logic        frame_done;
  logic        frame_err;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int done_base;
  int err_base;

  logic signed [15:0] fr_re [1024];
  logic signed [15:0] fr_im [1024];
  logic [15:0]        exp_bank [2][512];
  bit                 exp_sel;

  spectrum_mag_buffer #(
    .FFT_LEN         (1024),
    .FFT_RE_IM_WIDTH (16)
  ) dut (
    .clk_50m       (clk),
    .rst_n         (rst_n),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tdata  (tdata),
    .m_axis_tlast  (tlast),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .bank_sel      (bank_sel),
    .frame_done    (frame_done),
    .frame_err     (frame_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
  end

  function automatic logic [15:0] ref_mag(input int re, input int im);
    int a, b, mx, mn;
    a  = (re < 0) ? -re : re;
    b  = (im < 0) ? -im : im;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return 16'(mx + mn / 4 + mn / 8);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    tvalid = 1'b0;
    tlast  = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic fill_random();
    for (int k = 0; k < 1024; k++) begin
      fr_re[k] = 16'($urandom);
      fr_im[k] = 16'($urandom);
    end
  endtask

  // Sends beats 0..nbeats-1; returns 1 ns after the edge accepting the final beat.
  task automatic send_frame(input int nbeats, input int last_at, input int duty);
    for (int k = 0; k < nbeats; k++) begin
      if (duty < 100) begin
        while (int'($urandom_range(99)) >= duty) begin
          @(posedge clk);
          #1;
        end
      end
      tvalid = 1'b1;
      tdata  = {fr_re[k], fr_im[k]};
      tlast  = (k == last_at);
      if (k < 512) exp_bank[exp_sel][k] = ref_mag(int'(fr_re[k]), int'(fr_im[k]));
      @(posedge clk);
      #1;
      tvalid = 1'b0;
      tlast  = 1'b0;
    end
  endtask

  task automatic flush();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_display(input string tag);
    for (int a = 0; a < 512; a++) begin
      rd_addr = 9'(a);
      @(posedge clk);
      #1;
      check(tag, 32'(rd_data), 32'(exp_bank[int'(!exp_sel)][a]));
    end
  endtask

  task automatic read_one(input int a, output logic [15:0] d);
    rd_addr = 9'(a);
    @(posedge clk);
    #1;
    d = rd_data;
  endtask

  initial begin
    logic [15:0] d;
    tvalid  = 1'b0;
    tlast   = 1'b0;
    tdata   = '0;
    rd_addr = '0;
    rst_n   = 1'b0;
    exp_sel = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tready", 32'(tready), 0);
    check("rst_bank_sel", 32'(bank_sel), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_err", 32'(frame_err), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("tready_after_release", 32'(tready), 1);

    // Magnitude with hand-computed bins and publish timing
    for (int k = 0; k < 1024; k++) begin
      fr_re[k] = '0;
      fr_im[k] = '0;
    end
    fr_re[0] = 16'sh7FFF;
    fr_re[1] = 16'sh8000;
    fr_im[1] = 16'sh8000;
    fr_re[2] = -16'sd300;
    fr_im[2] = 16'sd400;
    done_base = done_cnt;
    err_base  = err_cnt;
    send_frame(1024, 1023, 100);
    check("mag_done_not_early", 32'(frame_done), 0);
    check("mag_bank_not_early", 32'(bank_sel), 0);
    @(posedge clk);
    #1;
    check("mag_done_pulse", 32'(frame_done), 1);
    check("mag_bank_swap", 32'(bank_sel), 1);
    @(posedge clk);
    #1;
    check("mag_done_one_cycle", 32'(frame_done), 0);
    exp_sel = 1'b1;
    flush();
    check("mag_done_count", 32'(done_cnt - done_base), 1);
    check("mag_err_count", 32'(err_cnt - err_base), 0);
    read_one(0, d);
    check("mag_bin0", 32'(d), 32767);
    read_one(1, d);
    check("mag_bin1", 32'(d), 45056);
    read_one(2, d);
    check("mag_bin2", 32'(d), 512);
    read_one(511, d);
    check("mag_bin511", 32'(d), 0);

    // Bursty input over three frames starting from reset
    do_reset();
    exp_sel = 1'b0;
    check("burst_bank_after_reset", 32'(bank_sel), 0);
    done_base = done_cnt;
    err_base  = err_cnt;
    for (int f = 0; f < 3; f++) begin
      fill_random();
      send_frame(1024, 1023, 30);
      flush();
      exp_sel = ~exp_sel;
      check("burst_bank_sel", 32'(bank_sel), 32'(exp_sel));
      check_display("burst_readback");
    end
    check("burst_done_count", 32'(done_cnt - done_base), 3);
    check("burst_err_count", 32'(err_cnt - err_base), 0);

    // Early tlast
    fill_random();
    send_frame(1024, 1023, 100);
    flush();
    exp_sel = ~exp_sel;
    check_display("early_frameA");
    done_base = done_cnt;
    err_base  = err_cnt;
    fill_random();
    send_frame(601, 600, 100);
    flush();
    check("early_err_count", 32'(err_cnt - err_base), 1);
    check("early_done_count", 32'(done_cnt - done_base), 0);
    check("early_bank_sel", 32'(bank_sel), 32'(exp_sel));
    check_display("early_keeps_frameA");
    fill_random();
    send_frame(1024, 1023, 100);
    flush();
    exp_sel = ~exp_sel;
    check("early_frameC_done", 32'(done_cnt - done_base), 1);
    check("early_frameC_bank", 32'(bank_sel), 32'(exp_sel));
    check_display("early_frameC");

    // Missing tlast
    done_base = done_cnt;
    err_base  = err_cnt;
    fill_random();
    send_frame(1024, -1, 100);
    flush();
    check("miss_err_count", 32'(err_cnt - err_base), 1);
    check("miss_done_count", 32'(done_cnt - done_base), 0);
    check("miss_bank_sel", 32'(bank_sel), 32'(exp_sel));
    fill_random();
    send_frame(1024, 1023, 100);
    flush();
    exp_sel = ~exp_sel;
    check("miss_next_done", 32'(done_cnt - done_base), 1);
    check("miss_next_bank", 32'(bank_sel), 32'(exp_sel));
    check_display("miss_next_frame");

    // Mid-frame reset
    fill_random();
    send_frame(1024, 1023, 100);
    flush();
    exp_sel = ~exp_sel;
    done_base = done_cnt;
    err_base  = err_cnt;
    fill_random();
    send_frame(301, -1, 100);
    do_reset();
    exp_sel = 1'b0;
    flush();
    check("midrst_no_done", 32'(done_cnt - done_base), 0);
    check("midrst_no_err", 32'(err_cnt - err_base), 0);
    check("midrst_bank_sel", 32'(bank_sel), 0);
    fill_random();
    send_frame(1024, 1023, 100);
    flush();
    exp_sel = 1'b1;
    check("midrst_done", 32'(done_cnt - done_base), 1);
    check("midrst_bank_swap", 32'(bank_sel), 1);
    check_display("midrst_frame");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
